// File: rtl/siphash_msg_ctrl.sv
// ---------------------------------------------------------------------------
// siphash_msg_ctrl
//
// Message sequencer placed between the bus-facing wrapper and siphash_core.
// It takes a key plus a stream of 64-bit little-endian message words and
// issues the core's initalize / compress / finalize commands. It also applies
// SipHash length padding and returns a 64-bit tag.
//
// Handshake: a message word is transferred on a rising clock edge where both
// in_valid and in_ready are 1. in_ready depends only on registered state, so
// it has no combinational path from any input. The producer keeps in_data,
// in_last and in_bytes stable while in_valid=1 and in_ready=0.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   start, key                begin a message; key sampled in the same cycle
//   in_valid/in_ready         message word handshake
//   in_data/in_last/in_bytes  word, last flag, valid byte count of last word
//   busy                      a message is in progress
//   hash, hash_valid          tag (held) and one-cycle update pulse
//   err                       one-cycle pulse: in_bytes > 8 on an accepted last word
//   core_*                    command/data interface to siphash_core
//   o_dbg_state               current FSM state, for observation only
// ---------------------------------------------------------------------------
module siphash_msg_ctrl #(
  parameter int unsigned C_ROUNDS = 2,
  parameter int unsigned D_ROUNDS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_last,
  input  logic [3:0]   in_bytes,
  output logic         busy,
  output logic [63:0]  hash,
  output logic         hash_valid,
  output logic         err,
  output logic         core_initalize,
  output logic         core_compress,
  output logic         core_finalize,
  output logic         core_long,
  output logic [3:0]   core_compression_rounds,
  output logic [3:0]   core_final_rounds,
  output logic [127:0] core_key,
  output logic [63:0]  core_mi,
  input  logic         core_ready,
  input  logic [127:0] core_word,
  input  logic         core_word_valid,
  output logic [2:0]   o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_GET   = 3'd2,
    S_COMP  = 3'd3,
    S_CWAIT = 3'd4,
    S_FIN   = 3'd5,
    S_FWAIT = 3'd6
  } state_t;

  state_t         r_state;
  logic [127:0]   r_key;
  logic [63:0]    r_mi;
  logic [7:0]     r_len;
  logic           r_pad_pend;
  logic           r_final;
  logic [63:0]    r_hash;
  logic           r_hash_valid;
  logic           r_err;
  logic           r_init;
  logic           r_comp;
  logic           r_fin;
  // Counts down after every command. The core reports ready/valid one cycle
  // late, so its flags are ignored until this count reaches zero. Covers the
  // command cycle itself plus one guard cycle.
  logic [1:0]     r_guard;

  logic [3:0]     w_n;
  logic [7:0]     w_len_last;
  logic [63:0]    w_pad_mi;

  // A byte count above 8 is treated as a full word.
  assign w_n        = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign w_len_last = r_len + {4'd0, w_n};

  // Short final word: keep bytes 0..n-1, clear the rest, and place the
  // low 8 bits of the total length in the top byte.
  always_comb begin
    w_pad_mi = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(w_n)) w_pad_mi[i*8 +: 8] = in_data[i*8 +: 8];
    end
    w_pad_mi[63:56] = w_len_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_key        <= '0;
      r_mi         <= '0;
      r_len        <= '0;
      r_pad_pend   <= 1'b0;
      r_final      <= 1'b0;
      r_hash       <= '0;
      r_hash_valid <= 1'b0;
      r_err        <= 1'b0;
      r_init       <= 1'b0;
      r_comp       <= 1'b0;
      r_fin        <= 1'b0;
      r_guard      <= '0;
    end else begin
      r_init       <= 1'b0;
      r_comp       <= 1'b0;
      r_fin        <= 1'b0;
      r_hash_valid <= 1'b0;
      r_err        <= 1'b0;
      if (r_guard != 2'd0) r_guard <= r_guard - 2'd1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key      <= key;
            r_len      <= '0;
            r_pad_pend <= 1'b0;
            r_final    <= 1'b0;
            r_state    <= S_INIT;
          end
        end
        S_INIT: begin
          if (core_ready) begin
            r_init  <= 1'b1;
            r_guard <= 2'd2;
            r_state <= S_GET;
          end
        end
        S_GET: begin
          if (in_valid && (r_guard == 2'd0)) begin
            if (!in_last || (w_n == 4'd8)) begin
              // Full word. A full last word still needs a separate
              // length-only padding block afterwards.
              r_mi       <= in_data;
              r_len      <= r_len + 8'd8;
              r_pad_pend <= in_last;
            end else begin
              r_mi    <= w_pad_mi;
              r_final <= 1'b1;
            end
            r_err   <= in_last && (in_bytes > 4'd8);
            r_state <= S_COMP;
          end
        end
        S_COMP: begin
          if (core_ready) begin
            r_comp  <= 1'b1;
            r_guard <= 2'd2;
            r_state <= S_CWAIT;
          end
        end
        S_CWAIT: begin
          if ((r_guard == 2'd0) && core_ready) begin
            if (r_pad_pend) begin
              r_mi       <= {r_len, 56'h0};
              r_pad_pend <= 1'b0;
              r_final    <= 1'b1;
              r_state    <= S_COMP;
            end else if (r_final) begin
              r_state <= S_FIN;
            end else begin
              r_state <= S_GET;
            end
          end
        end
        S_FIN: begin
          if (core_ready) begin
            r_fin   <= 1'b1;
            r_guard <= 2'd2;
            r_state <= S_FWAIT;
          end
        end
        S_FWAIT: begin
          if ((r_guard == 2'd0) && core_ready && core_word_valid) begin
            r_hash       <= core_word[127:64] ^ core_word[63:0];
            r_hash_valid <= 1'b1;
            r_final      <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready                = (r_state == S_GET) && (r_guard == 2'd0);
  assign busy                    = (r_state != S_IDLE);
  assign hash                    = r_hash;
  assign hash_valid              = r_hash_valid;
  assign err                     = r_err;
  assign core_initalize          = r_init;
  assign core_compress           = r_comp;
  assign core_finalize           = r_fin;
  assign core_long               = 1'b0;
  assign core_compression_rounds = 4'(C_ROUNDS);
  assign core_final_rounds       = 4'(D_ROUNDS);
  assign core_key                = r_key;
  assign core_mi                 = r_mi;
  assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_siphash_msg_ctrl
//
// Drives siphash_msg_ctrl against a behavioural SipHash core. Expected core_mi
// values and tags are constants taken from the SipHash-2-4 reference vectors
// (key 00..0f). They are pushed into queues as stimulus is issued, and a
// negedge monitor pops and compares each compress and each tag as they occur.
// ---------------------------------------------------------------------------
module tb_siphash_msg_ctrl;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [127:0] key;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_last;
  logic [3:0]   in_bytes;
  logic         busy;
  logic [63:0]  hash;
  logic         hash_valid;
  logic         err;
  logic         core_initalize;
  logic         core_compress;
  logic         core_finalize;
  logic         core_long;
  logic [3:0]   core_compression_rounds;
  logic [3:0]   core_final_rounds;
  logic [127:0] core_key;
  logic [63:0]  core_mi;
  logic         core_ready;
  logic [127:0] core_word;
  logic         core_word_valid;
  logic [2:0]   dbg_state;

  siphash_msg_ctrl #(.C_ROUNDS(2), .D_ROUNDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes), .busy(busy), .hash(hash),
    .hash_valid(hash_valid), .err(err), .core_initalize(core_initalize),
    .core_compress(core_compress), .core_finalize(core_finalize),
    .core_long(core_long), .core_compression_rounds(core_compression_rounds),
    .core_final_rounds(core_final_rounds), .core_key(core_key),
    .core_mi(core_mi), .core_ready(core_ready), .core_word(core_word),
    .core_word_valid(core_word_valid), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];   // expected core_mi per compress
  logic [63:0] hash_q[$];  // expected tags
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_hash = 0;
  int n_err  = 0;
  int lat_comp = 2;        // core busy time after a compress

  localparam logic [127:0] K = 128'h0f0e0d0c0b0a0908_0706050403020100;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural SipHash core ----------------
  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic logic [255:0] sipr(input logic [255:0] s, input int n);
    logic [63:0] a, b, c, d;
    {a, b, c, d} = s;
    for (int i = 0; i < n; i++) begin
      a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
      c = c + d; d = rotl(d, 16); d = d ^ c;
      a = a + d; d = rotl(d, 21); d = d ^ a;
      c = c + b; b = rotl(b, 17); b = b ^ c; c = rotl(c, 32);
    end
    return {a, b, c, d};
  endfunction

  logic [63:0]  m_v0, m_v1, m_v2, m_v3;
  logic [127:0] m_res;
  logic         m_pend, m_pend_init, m_pend_fin;
  int           m_cnt, m_lat;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready      <= 1'b1;
      core_word       <= '0;
      core_word_valid <= 1'b0;
      m_pend          <= 1'b0;
      m_pend_init     <= 1'b0;
      m_pend_fin      <= 1'b0;
      m_cnt           <= 0;
      m_lat           <= 2;
    end else begin
      if (core_initalize) begin
        m_v0 = core_key[63:0]   ^ 64'h736f6d6570736575;
        m_v1 = core_key[127:64] ^ 64'h646f72616e646f6d;
        m_v2 = core_key[63:0]   ^ 64'h6c7967656e657261;
        m_v3 = core_key[127:64] ^ 64'h7465646279746573;
        m_pend <= 1'b1; m_pend_init <= 1'b1; m_lat <= 2;
      end
      if (core_compress) begin
        m_v3 = m_v3 ^ core_mi;
        {m_v0, m_v1, m_v2, m_v3} = sipr({m_v0, m_v1, m_v2, m_v3}, int'(core_compression_rounds));
        m_v0 = m_v0 ^ core_mi;
        m_pend <= 1'b1; m_lat <= lat_comp;
      end
      if (core_finalize) begin
        m_v2 = m_v2 ^ 64'hff;
        {m_v0, m_v1, m_v2, m_v3} = sipr({m_v0, m_v1, m_v2, m_v3}, int'(core_final_rounds));
        m_res = {m_v0 ^ m_v1, m_v2 ^ m_v3};
        m_pend <= 1'b1; m_pend_fin <= 1'b1; m_lat <= 2;
      end
      // Flags change one cycle after the command is seen.
      if (m_pend) begin
        m_pend     <= 1'b0;
        core_ready <= 1'b0;
        m_cnt      <= m_lat;
        if (m_pend_init) begin
          core_word_valid <= 1'b0;
          m_pend_init     <= 1'b0;
        end
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          core_ready <= 1'b1;
          if (m_pend_fin) begin
            core_word       <= m_res;
            core_word_valid <= 1'b1;
            m_pend_fin      <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (core_initalize || core_compress || core_finalize)
        check("cmd_while_core_not_ready", {127'd0, core_ready}, 128'd1);
      if (in_ready)
        check("in_ready_implies_busy", {127'd0, busy}, 128'd1);
      if (core_compress) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_compress: got mi %h expected none", core_mi);
        end else begin
          check("core_mi", {64'd0, core_mi}, {64'd0, exp_q.pop_front()});
        end
      end
      if (hash_valid) begin
        n_hash++;
        if (hash_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_hash: got %h expected none", hash);
        end else begin
          check("hash", {64'd0, hash}, {64'd0, hash_q.pop_front()});
        end
      end
      if (err) n_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1; key = k;
    @(negedge clk);
    start = 1'b0; key = '0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("in_ready_timeout", 128'd0, 128'd1);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
  endtask

  task automatic wait_hash(input int target);
    int t;
    t = 0;
    while (n_hash < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("hash_count", 128'(n_hash), 128'(target));
  endtask

  // 15-byte message 00..0e; top byte of the last word is garbage.
  task automatic msg15(input int gap);
    exp_q.push_back(64'h0706050403020100);
    exp_q.push_back(64'h0f0e0d0c0b0a0908);
    hash_q.push_back(64'ha129ca6149be45e5);
    send_word(64'h0706050403020100, 1'b0, 4'd0, gap);
    send_word(64'hff0e0d0c0b0a0908, 1'b1, 4'd7, gap);
  endtask

  // ---------------- main sequence ----------------
  int hv0;
  initial begin
    reset_n = 1'b0; start = 1'b0; key = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy",     {127'd0, busy},       128'd0);
    check("rst_in_ready", {127'd0, in_ready},   128'd0);
    check("rst_hash",     {64'd0, hash},        128'd0);
    check("rst_cmds",     {125'd0, core_initalize, core_compress, core_finalize}, 128'd0);
    check("rst_key",      core_key,             128'd0);
    check("rst_mi",       {64'd0, core_mi},     128'd0);
    check("rst_state",    {125'd0, dbg_state},  128'd0);
    check("core_long",    {127'd0, core_long},  128'd0);
    check("c_rounds",     {124'd0, core_compression_rounds}, 128'd2);
    check("d_rounds",     {124'd0, core_final_rounds},       128'd4);

    // Empty message: one compress with mi=0, garbage data ignored
    do_start(K);
    check("busy_after_start", {127'd0, busy}, 128'd1);
    exp_q.push_back(64'h0);
    hash_q.push_back(64'h726fdb47dd0e0e31);
    send_word(64'hdeadbeefcafef00d, 1'b1, 4'd0, 0);
    wait_hash(1);
    check("latched_key", core_key, K);

    // 8-byte message, back-to-back start in the cycle after hash_valid
    do_start(K);
    exp_q.push_back(64'h0706050403020100);
    exp_q.push_back(64'h0800000000000000);
    hash_q.push_back(64'h93f5f5799a932462);
    send_word(64'h0706050403020100, 1'b1, 4'd8, 0);
    wait_hash(2);

    // 15-byte message
    do_start(K);
    msg15(0);
    wait_hash(3);
    check("hash_held", {64'd0, hash}, {64'd0, 64'ha129ca6149be45e5});

    // Input gaps and a 5-cycle core stall after each compress
    lat_comp = 5;
    do_start(K);
    msg15(3);
    wait_hash(4);
    lat_comp = 2;
    check("mi_q_drained_a", 128'(exp_q.size()), 128'd0);

    // start while busy is ignored; in_bytes=9 flags err, treated as 8
    do_start(K);
    @(negedge clk);
    start = 1'b1; key = ~K;
    @(negedge clk);
    start = 1'b0; key = '0;
    exp_q.push_back(64'h0706050403020100);
    exp_q.push_back(64'h0800000000000000);
    hash_q.push_back(64'h93f5f5799a932462);
    send_word(64'h0706050403020100, 1'b1, 4'd9, 0);
    wait_hash(5);
    check("err_count", 128'(n_err), 128'd1);
    check("key_unchanged", core_key, K);

    // Reset mid-message, then a fresh 15-byte message
    do_start(K);
    exp_q.push_back(64'h0706050403020100);
    send_word(64'h0706050403020100, 1'b0, 4'd0, 0);
    begin
      int t;
      t = 0;
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("mid_msg_in_ready", {127'd0, in_ready}, 128'd1);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy",  {127'd0, busy},     128'd0);
    check("abort_ready", {127'd0, in_ready}, 128'd0);
    check("abort_hash",  {64'd0, hash},      128'd0);
    check("abort_mi",    {64'd0, core_mi},   128'd0);
    check("abort_key",   core_key,           128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    hv0 = n_hash;
    do_start(K);
    msg15(0);
    wait_hash(hv0 + 1);
    repeat (30) @(negedge clk);
    check("one_hash_after_reset", 128'(n_hash), 128'(hv0 + 1));
    check("final_hash", {64'd0, hash}, {64'd0, 64'ha129ca6149be45e5});
    check("err_total", 128'(n_err), 128'd1);
    check("mi_q_drained", 128'(exp_q.size()), 128'd0);
    check("hash_q_drained", 128'(hash_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit
  initial begin
    #300000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
